// File: rtl/lfsr_tick_stepper.sv
// Galois LFSR stepped by a divider enable pulse, with a one-deep valid/ready output
// register, seed loading, lock-up guard, period detection and a sticky overrun flag.
module lfsr_tick_stepper #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_in,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             period_done,
   output logic             overrun,
   output logic             running
);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t             fsm_reg, fsm_next;
   logic [WIDTH-1:0] state_reg;
   logic [WIDTH-1:0] ref_seed_reg;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] out_data_reg;
   logic             out_valid_reg;
   logic             period_done_reg;
   logic             overrun_reg;

   logic             step;
   logic [WIDTH-1:0] seed_eff;
   logic [WIDTH-1:0] step_value;

   always_ff @(posedge clk) begin
      if (!rst_n) fsm_reg <= IDLE;
      else        fsm_reg <= fsm_next;
   end

   // stop dominates a coincident start
   always_comb begin
      fsm_next = fsm_reg;
      if (stop)       fsm_next = IDLE;
      else if (start) fsm_next = RUN;
   end

   assign running    = (fsm_reg == RUN);
   assign step       = running && tick_in && !load && !stop;
   assign seed_eff   = (seed_in == '0) ? SEED : seed_in;
   // an all-zero state would never leave zero, so it is replaced by SEED
   assign step_value = (state_reg == '0) ? SEED
                     : ((state_reg >> 1) ^ (state_reg[0] ? TAPS : '0));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= SEED;
         ref_seed_reg    <= SEED;
         count_reg       <= '0;
         out_data_reg    <= '0;
         out_valid_reg   <= 1'b0;
         period_done_reg <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         period_done_reg <= 1'b0;
         if (load) begin
            state_reg     <= seed_eff;
            ref_seed_reg  <= seed_eff;
            count_reg     <= '0;
            overrun_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
         end else if (step) begin
            state_reg <= step_value;
            if (step_value == ref_seed_reg) begin
               period_done_reg <= 1'b1;
               count_reg       <= '0;
            end else if (count_reg != '1) begin
               count_reg <= count_reg + WIDTH'(1);
            end
            // the held word is only replaced once it has been (or is being) consumed
            if (out_valid_reg && !out_ready) begin
               overrun_reg <= 1'b1;
            end else begin
               out_data_reg  <= step_value;
               out_valid_reg <= 1'b1;
            end
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_data    = out_data_reg;
   assign out_valid   = out_valid_reg;
   assign period_done = period_done_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_lfsr_tick_stepper.sv
// Self-checking bench for lfsr_tick_stepper: directed scenarios with literal expectations,
// randomized traffic and a full-period run, all compared each cycle against a behavioural model.
module tb_lfsr_tick_stepper;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam logic [15:0] TAPS = 16'hB400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_in = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        load = 1'b0;
   logic [15:0] seed_in = '0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        period_done;
   logic        overrun;
   logic        running;

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   lfsr_tick_stepper #(.WIDTH(16), .TAPS(TAPS), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start(start), .stop(stop),
      .load(load), .seed_in(seed_in), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .period_done(period_done), .overrun(overrun),
      .running(running)
   );

   // Behavioural model: what the observable outputs must be after each edge.
   typedef struct packed {
      logic [15:0] st;
      logic [15:0] rf;
      logic [15:0] data;
      logic        valid;
      logic        pd;
      logic        ovr;
      logic        run;
   } mdl_t;

   mdl_t m;

   function automatic logic [15:0] galois(input logic [15:0] x);
      if (x == 16'h0) return SEED;
      return (x >> 1) ^ ((x % 2 == 1) ? TAPS : 16'h0);
   endfunction

   function automatic mdl_t model_next(input mdl_t cur, input logic rn, input logic tk,
                                       input logic sa, input logic so, input logic ld,
                                       input logic [15:0] sd, input logic rdy);
      mdl_t n;
      logic [15:0] ns;
      n = cur;
      n.pd = 1'b0;
      if (!rn) begin
         n.st = SEED; n.rf = SEED; n.data = 16'h0;
         n.valid = 1'b0; n.ovr = 1'b0; n.run = 1'b0;
         return n;
      end
      if (ld) begin
         n.st = (sd == 16'h0) ? SEED : sd;
         n.rf = n.st;
         n.ovr = 1'b0;
         n.valid = 1'b0;
      end else if (cur.run && tk && !so) begin
         ns = galois(cur.st);
         n.st = ns;
         n.pd = (ns == cur.rf);
         if (cur.valid && !rdy) n.ovr = 1'b1;
         else begin
            n.data = ns;
            n.valid = 1'b1;
         end
      end else if (cur.valid && rdy) begin
         n.valid = 1'b0;
      end
      if (so)      n.run = 1'b0;
      else if (sa) n.run = 1'b1;
      return n;
   endfunction

   always @(posedge clk) begin
      m <= model_next(m, rst_n, tick_in, start, stop, load, seed_in, out_ready);
      if (!rst_n) chk_en <= 1'b1;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         tests += 5;
         if (out_data !== m.data) begin
            fails++; $display("FAIL cyc_out_data t=%0t got %h want %h", $time, out_data, m.data);
         end
         if (out_valid !== m.valid) begin
            fails++; $display("FAIL cyc_out_valid t=%0t got %b want %b", $time, out_valid, m.valid);
         end
         if (period_done !== m.pd) begin
            fails++; $display("FAIL cyc_period_done t=%0t got %b want %b", $time, period_done, m.pd);
         end
         if (overrun !== m.ovr) begin
            fails++; $display("FAIL cyc_overrun t=%0t got %b want %b", $time, overrun, m.ovr);
         end
         if (running !== m.run) begin
            fails++; $display("FAIL cyc_running t=%0t got %b want %b", $time, running, m.run);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end else begin
         $display("[TB] %s ok %h", name, act);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   int pulses;
   int pulse_at;

   initial begin
      // Reset and first steps
      cyc(); cyc();
      rst_n = 1'b1;
      check("reset_data", 32'(out_data), 32'h0);
      check("reset_valid", 32'(out_valid), 32'h0);
      check("reset_running", 32'(running), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      check("reset_pd", 32'(period_done), 32'h0);
      start = 1'b1; cyc(); start = 1'b0;
      check("start_running", 32'(running), 32'h1);
      out_ready = 1'b1; tick_in = 1'b1;
      cyc(); check("step1_data", 32'(out_data), 32'hE270);
      check("step1_valid", 32'(out_valid), 32'h1);
      cyc(); check("step2_data", 32'(out_data), 32'h7138);
      cyc(); check("step3_data", 32'(out_data), 32'h389C);
      tick_in = 1'b0;
      cyc(); check("drain_valid", 32'(out_valid), 32'h0);

      // Zero-seed load in IDLE
      stop = 1'b1; cyc(); stop = 1'b0;
      load = 1'b1; seed_in = 16'h0; cyc(); load = 1'b0;
      check("load_idle_running", 32'(running), 32'h0);
      start = 1'b1; cyc(); start = 1'b0;
      tick_in = 1'b1; cyc(); tick_in = 1'b0;
      check("zero_seed_data", 32'(out_data), 32'hE270);
      check("zero_seed_ovr", 32'(overrun), 32'h0);

      // Backpressure
      load = 1'b1; cyc(); load = 1'b0;
      out_ready = 1'b0; tick_in = 1'b1;
      cyc(); cyc();
      check("bp_hold_data", 32'(out_data), 32'hE270);
      check("bp_overrun", 32'(overrun), 32'h1);
      out_ready = 1'b1;
      cyc(); tick_in = 1'b0;
      check("bp_resume_data", 32'(out_data), 32'h389C);
      check("bp_resume_valid", 32'(out_valid), 32'h1);
      cyc(); check("bp_ovr_sticky", 32'(overrun), 32'h1);
      load = 1'b1; seed_in = 16'h0; cyc(); load = 1'b0;
      check("bp_ovr_cleared", 32'(overrun), 32'h0);

      // Simultaneous events
      load = 1'b1; seed_in = 16'h1234; tick_in = 1'b1; cyc(); load = 1'b0;
      check("load_tick_valid", 32'(out_valid), 32'h0);
      cyc(); tick_in = 1'b0;
      check("after_load_step", 32'(out_data), 32'h091A);
      cyc();
      stop = 1'b1; cyc(); stop = 1'b0;
      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      check("start_stop_idle", 32'(running), 32'h0);
      tick_in = 1'b1; cyc(); tick_in = 1'b0;
      check("idle_tick_valid", 32'(out_valid), 32'h0);

      // Reset mid-run
      start = 1'b1; cyc(); start = 1'b0;
      out_ready = 1'b0; tick_in = 1'b1; cyc(); cyc(); tick_in = 1'b0;
      check("pre_rst_ovr", 32'(overrun), 32'h1);
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      check("midrst_data", 32'(out_data), 32'h0);
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_ovr", 32'(overrun), 32'h0);
      check("midrst_running", 32'(running), 32'h0);
      start = 1'b1; cyc(); start = 1'b0;
      tick_in = 1'b1; cyc(); tick_in = 1'b0;
      check("post_rst_data", 32'(out_data), 32'hE270);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 299) != 0);
         tick_in   = ($urandom_range(0, 1) == 1);
         start     = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 19) == 0);
         load      = ($urandom_range(0, 39) == 0);
         seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      // Full period from SEED with tick held high
      rst_n = 1'b0; tick_in = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
      cyc(); rst_n = 1'b1;
      out_ready = 1'b1; tick_in = 1'b1; start = 1'b1;
      cyc(); start = 1'b0;
      pulses = 0; pulse_at = 0;
      for (int i = 1; i <= 65540; i++) begin
         cyc();
         if (period_done) begin
            pulses++;
            pulse_at = i;
            check("period_data", 32'(out_data), 32'hACE1);
         end
      end
      tick_in = 1'b0;
      check("period_pulses", 32'(pulses), 32'd1);
      check("period_length", 32'(pulse_at), 32'd65535);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
